// File: rtl/datapath_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_ctrl_pkg
// Brief    : Opcodes, ALU one-hot bit indices, FSM states and IR field offsets
// Revision : 1.0
// ============================================================================
package datapath_ctrl_pkg;

  localparam logic [4:0] c_op_add  = 5'd3;
  localparam logic [4:0] c_op_sub  = 5'd4;
  localparam logic [4:0] c_op_and  = 5'd5;
  localparam logic [4:0] c_op_or   = 5'd6;
  localparam logic [4:0] c_op_shr  = 5'd7;
  localparam logic [4:0] c_op_shra = 5'd8;
  localparam logic [4:0] c_op_shl  = 5'd9;
  localparam logic [4:0] c_op_ror  = 5'd10;
  localparam logic [4:0] c_op_rol  = 5'd11;
  localparam logic [4:0] c_op_mul  = 5'd15;
  localparam logic [4:0] c_op_div  = 5'd16;
  localparam logic [4:0] c_op_neg  = 5'd17;
  localparam logic [4:0] c_op_not  = 5'd18;

  // alu_op is one-hot with ADD in the MSB
  localparam int c_alu_w    = 13;
  localparam int c_alu_add  = 12;
  localparam int c_alu_sub  = 11;
  localparam int c_alu_shr  = 10;
  localparam int c_alu_shra = 9;
  localparam int c_alu_shl  = 8;
  localparam int c_alu_ror  = 7;
  localparam int c_alu_rol  = 6;
  localparam int c_alu_and  = 5;
  localparam int c_alu_or   = 4;
  localparam int c_alu_mul  = 3;
  localparam int c_alu_div  = 2;
  localparam int c_alu_neg  = 1;
  localparam int c_alu_not  = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic err;
    logic PCout;
    logic MDRout;
    logic Zhighout;
    logic Zlowout;
    logic HIout;
    logic LOout;
    logic PCin;
    logic MARin;
    logic MDRin;
    logic IRin;
    logic Zin;
    logic Yin;
    logic HIin;
    logic LOin;
    logic IncPC;
    logic Read;
  } strobe_t;

  function automatic int ra_lsb(input int opc_hi);
    return opc_hi - 8;
  endfunction

  function automatic int rb_lsb(input int opc_hi);
    return opc_hi - 12;
  endfunction

  function automatic int rc_lsb(input int opc_hi);
    return opc_hi - 16;
  endfunction

endpackage
`default_nettype wire

// File: rtl/op_decoder.sv
`default_nettype none
// ============================================================================
// Module   : op_decoder
// Brief    : Combinational IR decode: legality, class, ALU one-hot, reg one-hots
// Revision : 1.0
// ============================================================================
module op_decoder
  import datapath_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_HI   = 31
) (
  input  logic [DATA_W-1:0]   i_ir,
  output logic                o_legal,
  output logic                o_unary,
  output logic                o_muldiv,
  output logic [c_alu_w-1:0]  o_alu_op,
  output logic [NUM_REGS-1:0] o_ra_oh,
  output logic [NUM_REGS-1:0] o_rb_oh,
  output logic [NUM_REGS-1:0] o_rc_oh
);

  localparam int c_ra_lsb = ra_lsb(OPC_HI);
  localparam int c_rb_lsb = rb_lsb(OPC_HI);
  localparam int c_rc_lsb = rc_lsb(OPC_HI);

  logic [4:0] w_opc;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_op_ok;
  logic       w_regs_ok;
  logic       w_unused_ir;

  assign w_opc       = i_ir[OPC_HI -: 5];
  assign w_ra        = i_ir[c_ra_lsb +: 4];
  assign w_rb        = i_ir[c_rb_lsb +: 4];
  assign w_rc        = i_ir[c_rc_lsb +: 4];
  assign w_unused_ir = ^i_ir;

  always_comb begin
    o_alu_op = '0;
    w_op_ok  = 1'b1;
    o_unary  = 1'b0;
    o_muldiv = 1'b0;
    case (w_opc)
      c_op_add:  o_alu_op[c_alu_add]  = 1'b1;
      c_op_sub:  o_alu_op[c_alu_sub]  = 1'b1;
      c_op_and:  o_alu_op[c_alu_and]  = 1'b1;
      c_op_or:   o_alu_op[c_alu_or]   = 1'b1;
      c_op_shr:  o_alu_op[c_alu_shr]  = 1'b1;
      c_op_shra: o_alu_op[c_alu_shra] = 1'b1;
      c_op_shl:  o_alu_op[c_alu_shl]  = 1'b1;
      c_op_ror:  o_alu_op[c_alu_ror]  = 1'b1;
      c_op_rol:  o_alu_op[c_alu_rol]  = 1'b1;
      c_op_mul:  begin o_alu_op[c_alu_mul] = 1'b1; o_muldiv = 1'b1; end
      c_op_div:  begin o_alu_op[c_alu_div] = 1'b1; o_muldiv = 1'b1; end
      c_op_neg:  begin o_alu_op[c_alu_neg] = 1'b1; o_unary  = 1'b1; end
      c_op_not:  begin o_alu_op[c_alu_not] = 1'b1; o_unary  = 1'b1; end
      default:   w_op_ok = 1'b0;
    endcase
  end

  assign w_regs_ok = (32'(w_ra) < NUM_REGS) && (32'(w_rb) < NUM_REGS) &&
                     (32'(w_rc) < NUM_REGS);
  assign o_legal   = w_op_ok && w_regs_ok;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_onehot
    assign o_ra_oh[i] = (32'(w_ra) == i);
    assign o_rb_oh[i] = (32'(w_rb) == i);
    assign o_rc_oh[i] = (32'(w_rc) == i);
  end

endmodule
`default_nettype wire

// File: rtl/datapath_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : datapath_op_sequencer
// Brief    : Hardwired fetch/decode/execute control FSM for the DataPath.
//            Define SINGLE_STEP_EN to add a `step` input gating T0..T6.
// Revision : 1.0
// ============================================================================
module datapath_op_sequencer
  import datapath_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_HI   = 31
) (
  input  logic                Clock,
  input  logic                Clear,
`ifdef SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic                start,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   ir_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                PCout,
  output logic                MDRout,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                HIout,
  output logic                LOout,
  output logic                PCin,
  output logic                MARin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Zin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [c_alu_w-1:0]  alu_op
);

  state_t                r_state;
  state_t                w_nxt;
  strobe_t               r_ctl;
  strobe_t               w_ctl;
  logic [NUM_REGS-1:0]   r_rin,  w_rin;
  logic [NUM_REGS-1:0]   r_rout, w_rout;
  logic [c_alu_w-1:0]    r_alu,  w_alu;

  logic                  w_dec_legal, w_dec_unary, w_dec_muldiv;
  logic [c_alu_w-1:0]    w_dec_alu;
  logic [NUM_REGS-1:0]   w_dec_ra, w_dec_rb, w_dec_rc;

  logic                  r_legal, r_unary, r_muldiv;
  logic [c_alu_w-1:0]    r_dec_alu;
  logic [NUM_REGS-1:0]   r_ra, r_rb, r_rc;

  logic                  w_f_legal, w_f_unary, w_f_muldiv;
  logic [c_alu_w-1:0]    w_f_alu;
  logic [NUM_REGS-1:0]   w_f_ra, w_f_rb, w_f_rc;
  logic                  w_adv;
  logic                  w_entry;

`ifdef SINGLE_STEP_EN
  assign w_adv = step;
`else
  assign w_adv = 1'b1;
`endif

  op_decoder #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .OPC_HI   (OPC_HI)
  ) u_dec (
    .i_ir     (ir_in),
    .o_legal  (w_dec_legal),
    .o_unary  (w_dec_unary),
    .o_muldiv (w_dec_muldiv),
    .o_alu_op (w_dec_alu),
    .o_ra_oh  (w_dec_ra),
    .o_rb_oh  (w_dec_rb),
    .o_rc_oh  (w_dec_rc)
  );

  // T3 strobes are built on the T2->T3 edge from live decode; later states use the latched copy
  assign w_f_legal  = (r_state == T2) ? w_dec_legal  : r_legal;
  assign w_f_unary  = (r_state == T2) ? w_dec_unary  : r_unary;
  assign w_f_muldiv = (r_state == T2) ? w_dec_muldiv : r_muldiv;
  assign w_f_alu    = (r_state == T2) ? w_dec_alu    : r_dec_alu;
  assign w_f_ra     = (r_state == T2) ? w_dec_ra     : r_ra;
  assign w_f_rb     = (r_state == T2) ? w_dec_rb     : r_rb;
  assign w_f_rc     = (r_state == T2) ? w_dec_rc     : r_rc;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (start)              w_nxt = T0;
      T0:      if (w_adv)              w_nxt = T1;
      T1:      if (w_adv && mem_ack)   w_nxt = T2;
      T2:      if (w_adv)              w_nxt = T3;
      T3:      if (w_adv)              w_nxt = !w_f_legal ? IDLE : (w_f_unary ? T5 : T4);
      T4:      if (w_adv)              w_nxt = T5;
      T5:      if (w_adv)              w_nxt = w_f_muldiv ? T6 : IDLE;
      T6:      if (w_adv)              w_nxt = IDLE;
      default:                         w_nxt = IDLE;
    endcase
  end

  // PC/Z load strobes fire only on state entry so a held state never re-increments
  assign w_entry = (w_nxt != r_state);

  always_comb begin
    w_ctl      = '0;
    w_rin      = '0;
    w_rout     = '0;
    w_alu      = '0;
    w_ctl.busy = (w_nxt != IDLE);
    w_ctl.done = (w_nxt == IDLE) && ((r_state == T5) || (r_state == T6));
    w_ctl.err  = (w_nxt == IDLE) && (r_state == T3);
    case (w_nxt)
      T0: begin
        w_ctl.PCout = 1'b1;
        w_ctl.MARin = 1'b1;
        w_ctl.IncPC = w_entry;
        w_ctl.Zin   = w_entry;
      end
      T1: begin
        w_ctl.Read    = 1'b1;
        w_ctl.MDRin   = 1'b1;
        w_ctl.Zlowout = w_entry;
        w_ctl.PCin    = w_entry;
      end
      T2: begin
        w_ctl.MDRout = 1'b1;
        w_ctl.IRin   = 1'b1;
      end
      T3: begin
        if (w_f_legal) begin
          w_rout = w_f_rb;
          if (w_f_unary) begin
            w_alu     = w_f_alu;
            w_ctl.Zin = w_entry;
          end else begin
            w_ctl.Yin = 1'b1;
          end
        end
      end
      T4: begin
        w_rout    = w_f_rc;
        w_alu     = w_f_alu;
        w_ctl.Zin = w_entry;
      end
      T5: begin
        w_ctl.Zlowout = 1'b1;
        if (w_f_muldiv) w_ctl.LOin = 1'b1;
        else            w_rin      = w_f_ra;
      end
      T6: begin
        w_ctl.Zhighout = 1'b1;
        w_ctl.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state   <= IDLE;
      r_ctl     <= '0;
      r_rin     <= '0;
      r_rout    <= '0;
      r_alu     <= '0;
      r_legal   <= 1'b0;
      r_unary   <= 1'b0;
      r_muldiv  <= 1'b0;
      r_dec_alu <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rc      <= '0;
    end else begin
      r_state <= w_nxt;
      r_ctl   <= w_ctl;
      r_rin   <= w_rin;
      r_rout  <= w_rout;
      r_alu   <= w_alu;
      if ((r_state == T2) && (w_nxt == T3)) begin
        r_legal   <= w_dec_legal;
        r_unary   <= w_dec_unary;
        r_muldiv  <= w_dec_muldiv;
        r_dec_alu <= w_dec_alu;
        r_ra      <= w_dec_ra;
        r_rb      <= w_dec_rb;
        r_rc      <= w_dec_rc;
      end
    end
  end

  assign busy     = r_ctl.busy;
  assign done     = r_ctl.done;
  assign err      = r_ctl.err;
  assign PCout    = r_ctl.PCout;
  assign MDRout   = r_ctl.MDRout;
  assign Zhighout = r_ctl.Zhighout;
  assign Zlowout  = r_ctl.Zlowout;
  assign HIout    = r_ctl.HIout;
  assign LOout    = r_ctl.LOout;
  assign PCin     = r_ctl.PCin;
  assign MARin    = r_ctl.MARin;
  assign MDRin    = r_ctl.MDRin;
  assign IRin     = r_ctl.IRin;
  assign Zin      = r_ctl.Zin;
  assign Yin      = r_ctl.Yin;
  assign HIin     = r_ctl.HIin;
  assign LOin     = r_ctl.LOin;
  assign IncPC    = r_ctl.IncPC;
  assign Read     = r_ctl.Read;
  assign Rin      = r_rin;
  assign Rout     = r_rout;
  assign alu_op   = r_alu;

endmodule
`default_nettype wire
